// File: rtl/stmt_lowerer_sched_pkg.sv
// +-------------------------------------------------------------------------+
// | stmt_lowerer_sched_pkg : shared types and parameter checks for the      |
// |   round-robin lane scheduler.               Revision: 1.0               |
// +-------------------------------------------------------------------------+
`default_nettype none

package stmt_lowerer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        HOLD  = 2'b10
    } sched_state_e;

    typedef enum logic [1:0] {
        OP_FIELD = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_XOR   = 2'b11
    } lane_op_e;

    function automatic bit hold_cycles_valid(input int hold_cycles);
        return (hold_cycles >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stmt_lowerer_rr_pick.sv
// +-------------------------------------------------------------------------+
// | stmt_lowerer_rr_pick : combinational rotating-priority picker, first    |
// |   set request at or after rr_ptr wins.      Revision: 1.0               |
// +-------------------------------------------------------------------------+
`default_nettype none

module stmt_lowerer_rr_pick
    import stmt_lowerer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   winner
);

    int unsigned w_cand;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_cand = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Modulo by subtraction so non-power-of-two NUM_REQ wraps correctly.
            w_cand = int'(rr_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!valid && req[PTR_W'(w_cand)]) begin
                valid  = 1'b1;
                winner = PTR_W'(w_cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stmt_lowerer_lane_sched.sv
// +-------------------------------------------------------------------------+
// | stmt_lowerer_lane_sched : round-robin read-modify-write scheduler on a  |
// |   shared result register. Option macro: STMT_LOWERER_LANE_SCHED_PARITY_EN. Rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

module stmt_lowerer_lane_sched
    import stmt_lowerer_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int FIELD_W     = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*2-1:0]                req_op,
    input  logic [NUM_REQ*$clog2(DATA_W)-1:0]   req_idx,
    input  logic [NUM_REQ*FIELD_W-1:0]          req_data,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic                                busy,
    output logic                                done,
    output logic [DATA_W-1:0]                   y,
    output logic                                y_par
);

    localparam int IDX_W  = $clog2(DATA_W);
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

    generate
        if (!hold_cycles_valid(HOLD_CYCLES)) begin : g_hold_chk
            $error("HOLD_CYCLES must be >= 1");
        end
    endgenerate

    sched_state_e        r_state;
    sched_state_e        w_state_next;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_winner;
    logic [HCNT_W-1:0]   r_hold_cnt;
    lane_op_e            r_op;
    logic [IDX_W-1:0]    r_idx;
    logic [FIELD_W-1:0]  r_data;

    logic                w_valid;
    logic [PTR_W-1:0]    w_winner;
    logic                w_grant;
    logic                w_hold_done;
    lane_op_e            w_sel_op;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [FIELD_W-1:0]  w_sel_data;
    logic [DATA_W-1:0]   w_fdata;
    logic [DATA_W-1:0]   w_fmask;
    logic [DATA_W-1:0]   w_bmask;
    logic [DATA_W-1:0]   w_y_next;

    stmt_lowerer_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_valid),
        .winner (w_winner)
    );

    assign busy        = (r_state != IDLE);
    assign w_grant     = (r_state == IDLE) && w_valid;
    assign w_hold_done = (r_state == HOLD) && (r_hold_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_state_next = WRITE;
            WRITE:   w_state_next = HOLD;
            HOLD:    if (r_hold_cnt == '0) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_sel_op   = OP_FIELD;
        w_sel_idx  = '0;
        w_sel_data = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_winner == PTR_W'(r)) begin
                w_sel_op   = lane_op_e'(req_op[2*r +: 2]);
                w_sel_idx  = req_idx[IDX_W*r +: IDX_W];
                w_sel_data = req_data[FIELD_W*r +: FIELD_W];
            end
        end
    end

    // Shifting inside DATA_W drops field bits above the top edge; nothing wraps.
    assign w_fdata = DATA_W'(r_data) << r_idx;
    assign w_fmask = DATA_W'({FIELD_W{1'b1}}) << r_idx;
    assign w_bmask = DATA_W'(1) << r_idx;

    always_comb begin
        w_y_next = y;
        if (r_state == WRITE) begin
            for (int b = 0; b < DATA_W; b++) begin
                casez (r_op)
                    OP_FIELD: if (w_fmask[b]) w_y_next[b] = w_fdata[b];
                    OP_SET:   if (w_bmask[b]) w_y_next[b] = 1'b1;
                    OP_CLR:   if (w_bmask[b]) w_y_next[b] = 1'b0;
                    default:  if (w_fmask[b]) w_y_next[b] = y[b] ^ w_fdata[b];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt        <= '0;
            done       <= 1'b0;
            y          <= '0;
            r_rr_ptr   <= '0;
            r_winner   <= '0;
            r_hold_cnt <= '0;
            r_op       <= OP_FIELD;
            r_idx      <= '0;
            r_data     <= '0;
        end else begin
            done <= 1'b0;
            y    <= w_y_next;
            if (w_grant) begin
                r_winner <= w_winner;
                r_op     <= w_sel_op;
                r_idx    <= w_sel_idx;
                r_data   <= w_sel_data;
                gnt      <= NUM_REQ'(1) << w_winner;
            end
            if (r_state == WRITE) begin
                r_hold_cnt <= HCNT_W'(HOLD_CYCLES - 1);
            end else if ((r_state == HOLD) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
            if (w_hold_done) begin
                done     <= 1'b1;
                gnt      <= '0;
                r_rr_ptr <= (r_winner == PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
            end
        end
    end

`ifdef STMT_LOWERER_LANE_SCHED_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_par <= 1'b0;
        end else begin
            y_par <= ^w_y_next;
        end
    end
`else
    assign y_par = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stmt_lowerer_lane_sched.sv
// +-------------------------------------------------------------------------+
// | tb_stmt_lowerer_lane_sched : directed self-checking bench for the lane  |
// |   scheduler with hand-computed expectations.  Revision: 1.0             |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_stmt_lowerer_lane_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [11:0] req_idx;
    logic [7:0]  req_data;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [7:0]  y;
    logic        y_par;

    int n_vec;
    int n_err;

    stmt_lowerer_lane_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_op   (req_op),
        .req_idx  (req_idx),
        .req_data (req_data),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .y        (y),
        .y_par    (y_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] v);
`ifdef STMT_LOWERER_LANE_SCHED_PARITY_EN
        return ^v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int r, input logic [1:0] op, input int idx, input logic [1:0] data);
        req_op[2*r +: 2]   = op;
        req_idx[3*r +: 3]  = 3'(idx);
        req_data[2*r +: 2] = data;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One isolated transaction from requester r; leaves the bench in the done cycle.
    task automatic do_txn(input string tag, input int r, input logic [1:0] op, input int idx,
                          input logic [1:0] data, input logic [7:0] exp_y);
        set_lane(r, op, idx, data);
        req = 4'(1 << r);
        tick();
        check_vec({tag, "/gnt"}, 32'(gnt), 32'(1 << r));
        check_vec({tag, "/done_lo"}, 32'(done), 32'd0);
        req = '0;
        tick();
        check_vec({tag, "/y"}, 32'(y), 32'(exp_y));
        check_vec({tag, "/par"}, 32'(y_par), 32'(exp_par(exp_y)));
        tick();
        check_vec({tag, "/busy_hold"}, 32'(busy), 32'd1);
        tick();
        check_vec({tag, "/done"}, 32'(done), 32'd1);
        check_vec({tag, "/busy_end"}, 32'(busy), 32'd0);
        check_vec({tag, "/gnt_clr"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        req_op   = '0;
        req_idx  = '0;
        req_data = '0;
        do_reset();

        check_vec("rst/y", 32'(y), 32'h00);
        check_vec("rst/gnt", 32'(gnt), 32'h0);
        check_vec("rst/busy", 32'(busy), 32'd0);
        check_vec("rst/done", 32'(done), 32'd0);
        check_vec("rst/par", 32'(y_par), 32'd0);

        do_txn("basic", 0, 2'b00, 2, 2'b11, 8'h0C);

        // Round robin from rr_ptr=0 with all four requesting continuously.
        do_reset();
        for (int r = 0; r < 4; r++) set_lane(r, 2'b01, r, 2'b00);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_vec($sformatf("rr%0d/gnt", k), 32'(gnt), 32'(1 << (k % 4)));
            tick();
            tick();
            tick();
            check_vec($sformatf("rr%0d/done", k), 32'(done), 32'd1);
            if (k == 3) check_vec("rr/y", 32'(y), 32'h0F);
        end
        req = '0;

        // rr_ptr is 1: requester 1 runs, pointer moves to 2, then 0 beats 1.
        do_txn("pri_r1", 1, 2'b01, 5, 2'b00, 8'h2F);
        set_lane(0, 2'b01, 6, 2'b00);
        set_lane(1, 2'b01, 7, 2'b00);
        req = 4'b0011;
        tick();
        check_vec("pri/gnt0", 32'(gnt), 32'h1);
        tick();
        check_vec("pri/y0", 32'(y), 32'h6F);
        tick();
        tick();
        check_vec("pri/done0", 32'(done), 32'd1);
        tick();
        check_vec("pri/gnt1", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check_vec("pri/y1", 32'(y), 32'hEF);
        tick();
        tick();
        check_vec("pri/done1", 32'(done), 32'd1);

        do_reset();
        do_txn("trunc", 0, 2'b00, 7, 2'b11, 8'h80);

        do_txn("fill0", 0, 2'b00, 0, 2'b11, 8'h83);
        do_txn("fill2", 0, 2'b00, 2, 2'b11, 8'h8F);
        do_txn("fill4", 0, 2'b00, 4, 2'b11, 8'hBF);
        do_txn("fill6", 0, 2'b00, 6, 2'b11, 8'hFF);
        do_txn("xor", 2, 2'b11, 4, 2'b01, 8'hEF);
        do_txn("clr", 3, 2'b10, 0, 2'b00, 8'hEE);

        // Reset dropped in the first HOLD cycle aborts with no done pulse.
        set_lane(0, 2'b00, 0, 2'b01);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_vec("abort/y", 32'(y), 32'h00);
        check_vec("abort/gnt", 32'(gnt), 32'h0);
        check_vec("abort/busy", 32'(busy), 32'd0);
        check_vec("abort/done", 32'(done), 32'd0);
        check_vec("abort/par", 32'(y_par), 32'd0);
        tick();
        check_vec("abort/done2", 32'(done), 32'd0);

        do_txn("par_a", 0, 2'b00, 0, 2'b11, 8'h03);
        do_txn("par_b", 0, 2'b01, 2, 2'b00, 8'h07);
        tick();
        check_vec("par/hold_y", 32'(y), 32'h07);
        check_vec("par/hold_bit", 32'(y_par), 32'(exp_par(8'h07)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
